// File: rtl/div_arbiter.sv
// div_arbiter: two-requester front end for a shared iterative divider.
//
// Each requester presents {u, x, y} with a valid/ready handshake. One request
// is granted at a time; its operands are held on div_x/div_y/div_u while the
// divider runs. When the divider drops div_stall, the quotient and remainder
// are captured and returned on that requester's response port for one cycle.
// A zero divisor skips the divider: quot=ZERO_Q, rem=x, dz=1.
//
// Handshake: reqk_ready is high only in IDLE, only for the granted requester,
// and may depend combinationally on reqk_valid. A transfer happens on a rising
// clk edge where reqk_valid and reqk_ready are both high. respk_valid is a
// one-cycle pulse with no back-pressure; respk_quot/rem/dz hold until the
// next pulse on the same port.
//
// Ports:
//   clk, rst_n (async, active low), en (clock enable, forwarded to div_en)
//   req{0,1}_valid/_u/_x/_y in, req{0,1}_ready out
//   resp{0,1}_valid/_quot/_rem/_dz out
//   div_run/div_u/div_en/div_x/div_y out; div_stall/div_quot/div_rem in
//   busy out (high outside IDLE), dbg_state out (FSM state encoding)
//
// Configuration: define DIV_ARBITER_RR_EN for round-robin arbitration on
// ties; otherwise requester 0 has fixed priority.
module div_arbiter #(
  parameter logic [31:0] ZERO_Q = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        req0_valid,
  input  logic        req0_u,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_u,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_quot,
  output logic [31:0] resp0_rem,
  output logic        resp0_dz,
  output logic        resp1_valid,
  output logic [31:0] resp1_quot,
  output logic [31:0] resp1_rem,
  output logic        resp1_dz,
  output logic        div_run,
  output logic        div_u,
  output logic        div_en,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic        div_stall,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_CLR  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        gnt_id, gnt_q;
  logic        accept;
  logic        sel_u;
  logic [31:0] sel_x, sel_y;
  logic        op_u;
  logic [31:0] op_x, op_y;

  // Result load bus shared by the zero-divisor path and the divider capture.
  logic        ld_en, ld_id, ld_dz;
  logic [31:0] ld_quot, ld_rem;

  // ---------------- arbitration ----------------
`ifdef DIV_ARBITER_RR_EN
  logic last_gnt;

  // On a tie, the requester not granted last wins.
  always_comb begin
    if (req0_valid && req1_valid) gnt_id = ~last_gnt;
    else                          gnt_id = req1_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_gnt <= 1'b1;
    else if (accept) last_gnt <= gnt_id;
  end
`else
  // Requester 0 always wins when it is valid.
  assign gnt_id = ~req0_valid;
`endif

  assign accept = (state == S_IDLE) && (req0_valid || req1_valid);
  assign sel_u  = gnt_id ? req1_u : req0_u;
  assign sel_x  = gnt_id ? req1_x : req0_x;
  assign sel_y  = gnt_id ? req1_y : req0_y;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLR;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // CLR guarantees one enabled cycle with div_run low so the divider's
  // internal counter returns to zero before the next operation.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (sel_y == 32'd0) ? S_DONE : S_RUN;
      S_RUN:  if (!div_stall) state_nxt = S_DONE;
      S_DONE: state_nxt = en ? S_IDLE : S_CLR;
      S_CLR:  if (en) state_nxt = S_IDLE;
      default: state_nxt = S_CLR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req0_ready  = accept && !gnt_id;
    req1_ready  = accept &&  gnt_id;
    resp0_valid = (state == S_DONE) && !gnt_q;
    resp1_valid = (state == S_DONE) &&  gnt_q;
    div_run     = (state == S_RUN);
    busy        = (state != S_IDLE);
  end

  assign dbg_state = state;
  assign div_en    = en;
  assign div_u     = op_u;
  assign div_x     = op_x;
  assign div_y     = op_y;

  // ---------------- datapath ----------------
  always_comb begin
    ld_en   = 1'b0;
    ld_id   = gnt_q;
    ld_quot = div_quot;
    ld_rem  = div_rem;
    ld_dz   = 1'b0;
    if (accept && (sel_y == 32'd0)) begin
      ld_en   = 1'b1;
      ld_id   = gnt_id;
      ld_quot = ZERO_Q;
      ld_rem  = sel_x;
      ld_dz   = 1'b1;
    end else if ((state == S_RUN) && !div_stall) begin
      // Capture is independent of en: the divider signals completion itself.
      ld_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_u       <= 1'b0;
      op_x       <= 32'd0;
      op_y       <= 32'd0;
      gnt_q      <= 1'b0;
      resp0_quot <= 32'd0;
      resp0_rem  <= 32'd0;
      resp0_dz   <= 1'b0;
      resp1_quot <= 32'd0;
      resp1_rem  <= 32'd0;
      resp1_dz   <= 1'b0;
    end else begin
      if (accept) begin
        op_u  <= sel_u;
        op_x  <= sel_x;
        op_y  <= sel_y;
        gnt_q <= gnt_id;
      end
      if (ld_en && !ld_id) begin
        resp0_quot <= ld_quot;
        resp0_rem  <= ld_rem;
        resp0_dz   <= ld_dz;
      end
      if (ld_en && ld_id) begin
        resp1_quot <= ld_quot;
        resp1_rem  <= ld_rem;
        resp1_dz   <= ld_dz;
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req0_u = 0, req1_valid = 0, req1_u = 0;
  logic [31:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp0_dz, resp1_valid, resp1_dz;
  logic [31:0] resp0_quot, resp0_rem, resp1_quot, resp1_rem;
  logic        div_run, div_u, div_en, div_stall, busy;
  logic [31:0] div_x, div_y, div_quot, div_rem;
  logic [1:0]  dbg_state;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd3;

  int n_tests = 0;
  int n_fail  = 0;

  div_arbiter dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(req0_valid), .req0_u(req0_u), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_u(req1_u), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_quot(resp0_quot), .resp0_rem(resp0_rem), .resp0_dz(resp0_dz),
    .resp1_valid(resp1_valid), .resp1_quot(resp1_quot), .resp1_rem(resp1_rem), .resp1_dz(resp1_dz),
    .div_run(div_run), .div_u(div_u), .div_en(div_en), .div_x(div_x), .div_y(div_y),
    .div_stall(div_stall), .div_quot(div_quot), .div_rem(div_rem),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- divider model ----------------
  // Iterative divider: counts enabled run cycles, clears on an enabled idle
  // cycle, and releases stall on an enabled cycle once the count reaches 33.
  // Signed results use floor semantics (remainder takes the divisor's sign).
  logic [5:0] cnt = 6'd0;
  always_ff @(posedge clk) begin
    if (div_en) begin
      if (!div_run)          cnt <= 6'd0;
      else if (cnt != 6'd33) cnt <= cnt + 6'd1;
    end
  end
  assign div_stall = !((cnt == 6'd33) && div_en);

  logic signed [31:0] sq, sr;
  always_comb begin
    sq = 32'sd0;
    sr = 32'sd0;
    div_quot = 32'd0;
    div_rem  = 32'd0;
    if (div_y != 32'd0) begin
      if (div_u) begin
        sq = $signed(div_x) / $signed(div_y);
        sr = $signed(div_x) % $signed(div_y);
        if ((sr != 32'sd0) && ((sr < 0) != ($signed(div_y) < 0))) begin
          sq = sq - 32'sd1;
          sr = sr + $signed(div_y);
        end
        div_quot = sq;
        div_rem  = sr;
      end else begin
        div_quot = div_x / div_y;
        div_rem  = div_x % div_y;
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request on port k, waits for ready, then counts cycles from
  // the accept cycle until the response pulse. tog toggles en every cycle
  // after accept.
  task automatic do_req(input int k, input logic u, input logic [31:0] x, input logic [31:0] y,
                        input bit tog, output int lat, output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output bit saw_run, output bit ops_ok, output bit got);
    bit   acc;
    logic rdy, vld;
    lat = 0; q = 0; r = 0; dz = 0; saw_run = 0; ops_ok = 1; got = 0; acc = 0;
    en = 1'b1;
    if (k == 0) begin req0_u = u; req0_x = x; req0_y = y; req0_valid = 1'b1; end
    else        begin req1_u = u; req1_x = x; req1_y = y; req1_valid = 1'b1; end
    for (int w = 0; w < 300 && !acc; w++) begin
      #1;
      rdy = (k == 0) ? req0_ready : req1_ready;
      if (rdy) acc = 1;
      else begin @(posedge clk); #1; end
    end
    if (acc) begin
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat = 1;
      for (int c = 0; c < 400 && !got; c++) begin
        if (tog) en = ~en;
        #1;
        vld = (k == 0) ? resp0_valid : resp1_valid;
        if (div_run) begin
          saw_run = 1;
          if (div_x !== x || div_y !== y || div_u !== u) ops_ok = 0;
        end
        if (vld) begin
          got = 1;
          q  = (k == 0) ? resp0_quot : resp1_quot;
          r  = (k == 0) ? resp0_rem  : resp1_rem;
          dz = (k == 0) ? resp0_dz   : resp1_dz;
        end else begin
          @(posedge clk); #1;
          lat++;
        end
      end
    end else begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    en = 1'b1;
    #1;
    n_tests++;
    if (dbg_state !== ST_CLR) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_CLR); end
    n_tests++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, div_run} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshake: got %b want 00000", {req0_ready, req1_ready, resp0_valid, resp1_valid, div_run});
    end
    n_tests++;
    if ({resp0_quot, resp1_rem, div_x, div_y} !== 128'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_regs: quot0=%h rem1=%h x=%h y=%h busy=%b", resp0_quot, resp1_rem, div_x, div_y, busy);
    end
    @(posedge clk); #1;
    en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (dbg_state !== ST_CLR || busy !== 1'b1) begin n_fail++; $display("FAIL clr_wait_en: got %0d want %0d", dbg_state, ST_CLR); end
    en = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL clr_to_idle: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_arbitration();
    logic [0:0] exp_q[$];
    logic [0:0] exp_g;
    int  grants;
    bit  both_rdy, busy_rdy, done_ok;
`ifdef DIV_ARBITER_RR_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    grants = 0; both_rdy = 0; busy_rdy = 0; done_ok = 0;
    en = 1'b1;
    req0_u = 0; req0_x = 32'd100;         req0_y = 32'd7;
    req1_u = 1; req1_x = 32'hFFFFFFF9;    req1_y = 32'd2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 400 && grants < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) both_rdy = 1;
      if (busy && (req0_ready || req1_ready)) busy_rdy = 1;
      if (req0_ready || req1_ready) begin
        exp_g = exp_q.pop_front();
        n_tests++;
        if (req1_ready !== exp_g) begin n_fail++; $display("FAIL grant_%0d: got %0d want %0d", grants, req1_ready, exp_g); end
        grants++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_tests++;
    if (grants != 4) begin n_fail++; $display("FAIL grant_count: got %0d want 4", grants); end
    n_tests++;
    if (both_rdy || busy_rdy) begin n_fail++; $display("FAIL ready_exclusive: both=%0d while_busy=%0d want 0 0", both_rdy, busy_rdy); end
    for (int c = 0; c < 100 && !done_ok; c++) begin
      @(posedge clk); #1;
      if (!busy) done_ok = 1;
    end
    n_tests++;
    if (!done_ok) begin n_fail++; $display("FAIL arb_drain: busy=%b want 0", busy); end
  endtask

  task automatic test_divide();
    int lat; logic [31:0] q, r; logic dz; bit sr, ok, got;
    do_req(0, 1'b0, 32'd100, 32'd7, 0, lat, q, r, dz, sr, ok, got);
    n_tests++;
    if (!got || lat != 35) begin n_fail++; $display("FAIL div_latency: got %0d (seen=%0d) want 35", lat, got); end
    n_tests++;
    if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin n_fail++; $display("FAIL div_100_7: q=%0d r=%0d dz=%b want 14 2 0", q, r, dz); end
    n_tests++;
    if (!sr || !ok) begin n_fail++; $display("FAIL div_operands: run_seen=%0d stable=%0d want 1 1", sr, ok); end
    @(posedge clk); #1;
    n_tests++;
    if (resp0_valid !== 1'b0 || resp0_quot !== 32'd14 || resp0_rem !== 32'd2) begin
      n_fail++; $display("FAIL resp_pulse_hold: valid=%b q=%0d r=%0d want 0 14 2", resp0_valid, resp0_quot, resp0_rem);
    end
  endtask

  task automatic test_signed();
    int lat; logic [31:0] q, r; logic dz; bit sr, ok, got;
    do_req(1, 1'b1, 32'hFFFFFFF9, 32'd2, 0, lat, q, r, dz, sr, ok, got);
    n_tests++;
    if (!got || lat != 35 || q !== 32'hFFFFFFFC || r !== 32'd1 || dz !== 1'b0) begin
      n_fail++; $display("FAIL signed_m7_2: lat=%0d q=%h r=%h dz=%b want 35 fffffffc 00000001 0", lat, q, r, dz);
    end
    n_tests++;
    if (resp0_quot !== 32'd14 || resp0_rem !== 32'd2) begin n_fail++; $display("FAIL resp0_hold: q=%0d r=%0d want 14 2", resp0_quot, resp0_rem); end
    do_req(0, 1'b0, 32'hFFFFFFF9, 32'd2, 0, lat, q, r, dz, sr, ok, got);
    n_tests++;
    if (!got || q !== 32'h7FFFFFFC || r !== 32'd1) begin n_fail++; $display("FAIL unsigned_big: q=%h r=%h want 7ffffffc 00000001", q, r); end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] q, r; logic dz; bit sr, ok, got;
    do_req(0, 1'b0, 32'd55, 32'd0, 0, lat, q, r, dz, sr, ok, got);
    n_tests++;
    if (!got || lat != 1) begin n_fail++; $display("FAIL dz_latency: got %0d (seen=%0d) want 1", lat, got); end
    n_tests++;
    if (q !== 32'hFFFFFFFF || r !== 32'd55 || dz !== 1'b1 || sr) begin
      n_fail++; $display("FAIL dz_result: q=%h r=%0d dz=%b run=%0d want ffffffff 55 1 0", q, r, dz, sr);
    end
    do_req(1, 1'b1, 32'hDEADBEEF, 32'd0, 0, lat, q, r, dz, sr, ok, got);
    n_tests++;
    if (!got || lat != 1 || q !== 32'hFFFFFFFF || r !== 32'hDEADBEEF || dz !== 1'b1) begin
      n_fail++; $display("FAIL dz_req1: lat=%0d q=%h r=%h dz=%b want 1 ffffffff deadbeef 1", lat, q, r, dz);
    end
  endtask

  task automatic test_en_toggle();
    int lat; logic [31:0] q, r; logic dz; bit sr, ok, got;
    do_req(0, 1'b0, 32'd100, 32'd7, 1, lat, q, r, dz, sr, ok, got);
    n_tests++;
    if (!got || lat != 69 || q !== 32'd14 || r !== 32'd2) begin
      n_fail++; $display("FAIL en_toggle: lat=%0d q=%0d r=%0d want 69 14 2", lat, q, r);
    end
    // The response cycle had en low, so the FSM must pass through CLR.
    @(posedge clk); #1;
    en = 1'b0;
    n_tests++;
    if (dbg_state !== ST_CLR) begin n_fail++; $display("FAIL done_to_clr: got %0d want %0d", dbg_state, ST_CLR); end
    @(posedge clk); #1;
    en = 1'b1;
    n_tests++;
    if (dbg_state !== ST_CLR) begin n_fail++; $display("FAIL clr_hold: got %0d want %0d", dbg_state, ST_CLR); end
    @(posedge clk); #1;
    n_tests++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL clr_exit: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_reset_mid();
    int lat, resp_cnt; logic [31:0] q, r; logic dz; bit sr, ok, got, acc;
    acc = 0; resp_cnt = 0;
    en = 1'b1;
    req0_u = 0; req0_x = 32'd100; req0_y = 32'd7; req0_valid = 1'b1;
    for (int w = 0; w < 100 && !acc; w++) begin
      #1;
      if (req0_ready) acc = 1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!acc || dbg_state !== ST_CLR || div_run !== 1'b0 || resp0_quot !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset: acc=%0d state=%0d run=%b q=%h want 1 3 0 0", acc, dbg_state, div_run, resp0_quot);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (resp0_valid || resp1_valid) resp_cnt++;
    end
    n_tests++;
    if (resp_cnt != 0) begin n_fail++; $display("FAIL mid_reset_no_resp: got %0d want 0", resp_cnt); end
    do_req(0, 1'b0, 32'd200, 32'd9, 0, lat, q, r, dz, sr, ok, got);
    n_tests++;
    if (!got || lat != 35 || q !== 32'd22 || r !== 32'd2 || dz !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_div: lat=%0d q=%0d r=%0d dz=%b want 35 22 2 0", lat, q, r, dz);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_arbitration();
    test_divide();
    test_signed();
    test_div_zero();
    test_en_toggle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter ZERO_Q, default 32'hFFFFFFFF: quotient returned for divide-by-zero.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port en  in  1  global clock-enable; forwarded unchanged to div_en.
REQ-005 SHALL have, for each requester k in {0,1}, inputs reqk_valid (1), reqk_u (1, signed), reqk_x (32), reqk_y (32), and output reqk_ready (1).
REQ-006 SHALL have, for each requester k, outputs respk_valid (1), respk_quot (32), respk_rem (32), respk_dz (1, divide-by-zero).
REQ-007 SHALL have divider-side outputs div_run (1), div_u (1), div_en (1), div_x (32), div_y (32).
REQ-008 SHALL have divider-side inputs div_stall (1), div_quot (32), div_rem (32).
REQ-009 SHALL have output busy (1): high in every state except IDLE.

Function
REQ-010 SHALL implement a four-state FSM: IDLE, RUN, DONE, CLR.
REQ-011 In IDLE with at least one reqk_valid: grant exactly one requester, assert its reqk_ready combinationally in that cycle, latch u/x/y and the grant id.
REQ-012 reqk_ready SHALL be high only in IDLE and only for the granted requester; handshake completes when valid and ready are both high.
REQ-013 Accepted request with y != 0: next state RUN; with y == 0: next state DONE, divider not run.
REQ-014 div_x, div_y and div_u SHALL come from the latched operands and stay stable from accept until leaving RUN.
REQ-015 div_run SHALL be 1 in RUN only and 0 in IDLE, DONE and CLR.
REQ-016 In RUN, the cycle div_stall==0 is observed: capture div_quot/div_rem into result registers, go to DONE; capture does not depend on en.
REQ-017 In DONE: drive respg_valid high for exactly one cycle for granted requester g, with captured quot/rem and respg_dz=0.
REQ-018 Divide-by-zero result: quot=ZERO_Q, rem=latched x, dz=1.
REQ-019 respk_quot, respk_rem and respk_dz SHALL hold their last values until the next respk_valid.
REQ-020 DONE->IDLE if en==1 in the DONE cycle, else DONE->CLR; CLR->IDLE on the first cycle with en==1. This guarantees one enabled cycle with run low, returning the divider counter to 0.
REQ-021 Latency with en held high: accept at cycle T -> resp valid at T+35 (divide) or T+1 (y==0); en low cycles extend RUN/CLR one-for-one.
REQ-022 No new grant SHALL occur while busy; requests stay pending and are not dropped.

Reset
REQ-023 rst_n low SHALL force the FSM to CLR, div_run=0, and all ready/valid outputs to 0.
REQ-024 rst_n low SHALL clear all result and operand registers to 0, and set the last-grant pointer to 1 so requester 0 wins the first tie.
REQ-025 Reset mid-operation SHALL abandon the division with no response; after release the block waits in CLR for an en cycle.

Configuration
REQ-026 Macro DIV_ARBITER_RR_EN defined: round-robin; on a tie, grant the requester not granted last; pointer updates on every accept.
REQ-027 DIV_ARBITER_RR_EN undefined: fixed priority, requester 0 always beats requester 1; pointer logic absent.

Verification
REQ-028 Scenario: en=1, req0 x=100 y=7 u=0 -> ready0 at T, resp0_valid at T+35, quot=14, rem=2, dz=0.
REQ-029 Scenario: req1 x=-7 (32'hFFFFFFF9), y=2, u=1 -> resp1 quot=-4 (32'hFFFFFFFC), rem=1.
REQ-030 Scenario: req0 y=0 x=55 -> resp0_valid at T+1, quot=32'hFFFFFFFF, rem=55, dz=1, div_run never high.
REQ-031 Scenario: both valid continuously, RR_EN defined -> grants alternate 0,1,0,1; RR_EN undefined -> grant 0 every time.
REQ-032 Scenario: en toggled 1/0 each cycle during a 100/7 division -> same result, latency 69 cycles; DONE with en=0 passes through CLR.
REQ-033 Scenario: rst_n pulsed low at T+10 of a division -> no resp, next request after release returns correct result.
